// File: rtl/edge_pkg_a.sv
`default_nettype none
// ============================================================================
// Module      : edge_pkg_a
// Description : Narrow link beat type shared by every edge on the param link.
//               A beat carries one data byte and a 4-bit tag.
// Revision    : 1.0 - initial release
// ============================================================================
package edge_pkg_a;

    // Narrow beat: data byte in the upper bits, tag in the low nibble.
    typedef struct packed {
        logic [7:0] data;
        logic [3:0] tag;
    } param_t;

endpackage : edge_pkg_a
`default_nettype wire

// File: rtl/edge_pkg_b.sv
`default_nettype none
// ============================================================================
// Module      : edge_pkg_b
// Description : Wide producer word type: eight 8-bit fields, field 0 in the
//               least significant byte (word[i] is field_i).
// Revision    : 1.0 - initial release
// ============================================================================
package edge_pkg_b;

    typedef logic [7:0][7:0] wide_t;

endpackage : edge_pkg_b
`default_nettype wire

// File: rtl/wba_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wba_pkg
// Description : Shared types, constants and tag helpers for the wide beat
//               arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package wba_pkg;

    import edge_pkg_a::param_t;
    import edge_pkg_b::wide_t;

    // Sparse encoding; any code outside this set is treated as IDLE.
    typedef enum logic [3:0] {
        IDLE = 4'd0,
        SEND = 4'd3,
        LAST = 4'd7
    } wba_state_e;

    localparam int BEATS_PER_WORD = 8;
    localparam int LAST_BIT       = 3;
    localparam int IDX_MSB        = 2;

    // Beat index at which SEND hands over to LAST on the next handshake.
    localparam logic [IDX_MSB:0] IDX_PENULT = 3'(BEATS_PER_WORD - 2);

    // Tag layout: {last, beat_idx}.
    function automatic logic [LAST_BIT:0] make_tag(input logic             last,
                                                   input logic [IDX_MSB:0] idx);
        return {last, idx};
    endfunction

    // Build one beat of a captured word.
    function automatic param_t make_beat(input wide_t            word,
                                         input logic [IDX_MSB:0] idx,
                                         input logic             last);
        param_t beat;
        beat.data = word[idx];
        beat.tag  = make_tag(last, idx);
        return beat;
    endfunction

endpackage : wba_pkg
`default_nettype wire

// File: rtl/wba_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : wba_rr_pick
// Description : Combinational round-robin selector. Finds the first set bit
//               of req starting at ptr and moving upward with wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module wba_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    // Scan from the farthest offset down to offset 0 so the closest hit wins.
    always_comb begin
        logic [ID_W-1:0] w_k;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        w_k = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_k = ID_W'((int'(ptr) + i) % NUM_REQ);
            if (req[w_k]) begin
                gnt      = '0;
                gnt[w_k] = 1'b1;
                idx      = w_k;
                any      = 1'b1;
            end
        end
    end

endmodule : wba_rr_pick
`default_nettype wire

// File: rtl/wide_beat_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wide_beat_arbiter
// Description : Round-robin scheduler sharing one narrow param_t link among
//               NUM_REQ wide_t producers. The winning word is captured and
//               serialised as eight beats, field 0 first, tag = {last, idx}.
//               Optional macro WBA_PARITY_EN adds out_parity (XOR of the beat
//               data byte).
// Revision    : 1.0 - initial release
// ============================================================================
module wide_beat_arbiter
    import wba_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  edge_pkg_b::wide_t    req_data [NUM_REQ],
    output logic                 out_valid,
    input  logic                 out_ready,
    output edge_pkg_a::param_t   out_data,
    output logic [ID_W-1:0]      out_id
`ifdef WBA_PARITY_EN
    ,
    output logic                 out_parity
`endif
);

    wba_state_e          r_state;
    wba_state_e          w_state_dec;
    wba_state_e          w_state_next;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [ID_W-1:0]     r_out_id;
    logic [IDX_MSB:0]    r_beat_idx;
    edge_pkg_b::wide_t   r_capture;

    logic [NUM_REQ-1:0]  w_pick_gnt;
    logic [ID_W-1:0]     w_pick_idx;
    logic                w_pick_any;
    logic                w_grant;
    logic [ID_W-1:0]     w_ptr_next;

    wba_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req (req_valid),
        .ptr (r_rr_ptr),
        .gnt (w_pick_gnt),
        .idx (w_pick_idx),
        .any (w_pick_any)
    );

    // Fold unused state codes onto IDLE so a corrupted register recovers.
    always_comb begin
        case (r_state)
            SEND:    w_state_dec = SEND;
            LAST:    w_state_dec = LAST;
            default: w_state_dec = IDLE;
        endcase
    end

    // Next-state and handshake outputs; grants are only offered in IDLE.
    always_comb begin
        w_state_next = w_state_dec;
        req_ready    = '0;
        out_valid    = 1'b0;
        w_grant      = 1'b0;
        case (w_state_dec)
            IDLE: begin
                if (rst_n && w_pick_any) begin
                    req_ready    = w_pick_gnt;
                    w_grant      = 1'b1;
                    w_state_next = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                if (out_ready && (r_beat_idx == IDX_PENULT)) begin
                    w_state_next = LAST;
                end
            end
            LAST: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Pointer moves one past the requester whose word just completed.
    assign w_ptr_next = (r_out_id == ID_W'(NUM_REQ - 1)) ? '0 : r_out_id + ID_W'(1);

    // Word capture, beat counter, owner id and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_capture  <= '0;
            r_out_id   <= '0;
            r_beat_idx <= '0;
            r_rr_ptr   <= '0;
        end else begin
            if (w_grant) begin
                r_capture  <= req_data[w_pick_idx];
                r_out_id   <= w_pick_idx;
                r_beat_idx <= '0;
            end else if ((w_state_dec == SEND) && out_ready) begin
                r_beat_idx <= r_beat_idx + 3'd1;
            end
            if ((w_state_dec == LAST) && out_ready) begin
                r_rr_ptr <= w_ptr_next;
            end
        end
    end

    // Beat mux: driven purely from registers, so it holds while stalled.
    always_comb begin
        out_data = '0;
        if (out_valid) begin
            out_data = make_beat(r_capture, r_beat_idx, (w_state_dec == LAST));
        end
    end

    assign out_id = r_out_id;

`ifdef WBA_PARITY_EN
    assign out_parity = ^out_data.data;
`endif

endmodule : wide_beat_arbiter
`default_nettype wire
